// File: rtl/biriscv_divider_param.sv
`default_nettype none
// ============================================================================
// Module   : biriscv_divider_param
// Purpose  : Iterative integer divider for the biRISC-V execute stage.
//            Executes DIV, DIVU, REM and REMU on XLEN-bit operands using a
//            restoring algorithm that retires BITS_PER_CYCLE quotient bits per
//            cycle. Divide-by-zero and repeats of the last completed operation
//            can bypass the iteration and finish in a single cycle.
// Ports    : clk_i                clock
//            rst_ni               asynchronous reset, active low
//            opcode_valid_i       issue strobe
//            opcode_opcode_i      32-bit instruction word (decoded internally)
//            opcode_ra_operand_i  dividend
//            opcode_rb_operand_i  divisor
//            flush_i              abort in-flight op, invalidate result cache
//            opcode_ready_o       1 = an op can be accepted this cycle
//            busy_o               1 = an op is iterating or completing
//            writeback_valid_o    one-cycle result strobe
//            writeback_value_o    result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module biriscv_divider_param #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int LAST_OP_CACHE  = 1,
  parameter int EARLY_DIV0     = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            opcode_valid_i,
  input  logic [31:0]     opcode_opcode_i,
  input  logic [XLEN-1:0] opcode_ra_operand_i,
  input  logic [XLEN-1:0] opcode_rb_operand_i,
  input  logic            flush_i,
  output logic            opcode_ready_o,
  output logic            busy_o,
  output logic            writeback_valid_o,
  output logic [XLEN-1:0] writeback_value_o
);

  // RV32M instruction match values and the shared funct7/funct3/opcode mask
  localparam logic [31:0] c_INST_DIV_MASK = 32'hfe00_707f;
  localparam logic [31:0] c_INST_DIV      = 32'h0200_4033;
  localparam logic [31:0] c_INST_DIVU     = 32'h0200_5033;
  localparam logic [31:0] c_INST_REM      = 32'h0200_6033;
  localparam logic [31:0] c_INST_REMU     = 32'h0200_7033;

  // Internal operation code; bit 1 set = remainder result
  localparam logic [1:0] c_OP_DIV  = 2'd0;
  localparam logic [1:0] c_OP_DIVU = 2'd1;
  localparam logic [1:0] c_OP_REM  = 2'd2;
  localparam logic [1:0] c_OP_REMU = 2'd3;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  localparam int                c_STEPS    = XLEN / BITS_PER_CYCLE;
  localparam int                c_CNT_W    = $clog2(c_STEPS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(c_STEPS);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam int                c_DVS_W    = 2 * XLEN - 1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [XLEN-1:0]    r_dividend;   // running partial remainder
  logic [c_DVS_W-1:0] r_divisor;    // divisor, shifted right one place per step
  logic [XLEN-1:0]    r_quotient;
  logic [1:0]         r_op;
  logic               r_invert;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic               r_fast;
  logic [XLEN-1:0]    r_fast_res;
  logic               r_cache_valid;
  logic [XLEN-1:0]    r_cache_a;
  logic [XLEN-1:0]    r_cache_b;
  logic [1:0]         r_cache_op;
  logic [XLEN-1:0]    r_cache_res;
  logic               r_wb_valid;
  logic [XLEN-1:0]    r_wb_value;

  // --------------------------------------------------------------------------
  // Wires
  // --------------------------------------------------------------------------
  logic [1:0]         w_state_nxt;
  logic               w_is_div;
  logic               w_is_divu;
  logic               w_is_rem;
  logic               w_is_remu;
  logic               w_op_hit;
  logic [1:0]         w_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_a_mag;
  logic [XLEN-1:0]    w_b_mag;
  logic               w_b_zero;
  logic               w_invert;
  logic               w_cache_hit;
  logic               w_div0_fast;
  logic               w_fast;
  logic [XLEN-1:0]    w_fast_value;
  logic               w_accept;
  logic [XLEN-1:0]    w_step_rem;
  logic [XLEN-1:0]    w_step_quo;
  logic [c_DVS_W-1:0] w_step_dvs;
  logic               w_step_ge;
  logic [XLEN-1:0]    w_res_sel;
  logic [XLEN-1:0]    w_res_calc;
  logic [XLEN-1:0]    w_result;
  logic               w_unused_opcode;

  // --------------------------------------------------------------------------
  // Decode and operand preparation
  // --------------------------------------------------------------------------
  assign w_is_div  = (opcode_opcode_i & c_INST_DIV_MASK) == c_INST_DIV;
  assign w_is_divu = (opcode_opcode_i & c_INST_DIV_MASK) == c_INST_DIVU;
  assign w_is_rem  = (opcode_opcode_i & c_INST_DIV_MASK) == c_INST_REM;
  assign w_is_remu = (opcode_opcode_i & c_INST_DIV_MASK) == c_INST_REMU;
  assign w_op_hit  = w_is_div | w_is_divu | w_is_rem | w_is_remu;

  // Register-specifier fields do not affect the operation
  assign w_unused_opcode = ^(opcode_opcode_i & ~c_INST_DIV_MASK);

  always_comb begin
    w_op = c_OP_DIV;
    if (w_is_divu) w_op = c_OP_DIVU;
    if (w_is_rem)  w_op = c_OP_REM;
    if (w_is_remu) w_op = c_OP_REMU;
  end

  // Sign bits only count for the signed ops; magnitudes wrap (MIN stays MIN,
  // which is still the correct unsigned magnitude).
  assign w_a_neg  = ((w_op == c_OP_DIV) || (w_op == c_OP_REM)) && opcode_ra_operand_i[XLEN-1];
  assign w_b_neg  = ((w_op == c_OP_DIV) || (w_op == c_OP_REM)) && opcode_rb_operand_i[XLEN-1];
  assign w_a_mag  = w_a_neg ? -opcode_ra_operand_i : opcode_ra_operand_i;
  assign w_b_mag  = w_b_neg ? -opcode_rb_operand_i : opcode_rb_operand_i;
  assign w_b_zero = (opcode_rb_operand_i == '0);

  // Quotient sign differs when operand signs differ (x/0 keeps all-ones);
  // remainder takes the dividend's sign.
  assign w_invert = ((w_op == c_OP_DIV) && (w_a_neg != w_b_neg) && !w_b_zero) ||
                    ((w_op == c_OP_REM) && w_a_neg);

  assign w_cache_hit = (LAST_OP_CACHE != 0) && r_cache_valid &&
                       (r_cache_a == opcode_ra_operand_i) &&
                       (r_cache_b == opcode_rb_operand_i) &&
                       (r_cache_op == w_op);
  assign w_div0_fast = (EARLY_DIV0 != 0) && w_b_zero;
  assign w_fast      = w_cache_hit || w_div0_fast;

  // x/0: quotient is all ones, remainder is the dividend itself
  assign w_fast_value = w_cache_hit ? r_cache_res :
                        (w_op[1] ? opcode_ra_operand_i : {XLEN{1'b1}});

  assign w_accept = opcode_valid_i && opcode_ready_o && w_op_hit && !flush_i;

  // --------------------------------------------------------------------------
  // Restoring division: BITS_PER_CYCLE chained compare/subtract/shift steps
  // --------------------------------------------------------------------------
  always_comb begin
    w_step_rem = r_dividend;
    w_step_quo = r_quotient;
    w_step_dvs = r_divisor;
    w_step_ge  = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_step_ge = ({{(XLEN-1){1'b0}}, w_step_rem} >= w_step_dvs);
      // When the divisor fits, its upper bits are zero so the low slice is exact
      if (w_step_ge) begin
        w_step_rem = w_step_rem - w_step_dvs[XLEN-1:0];
      end
      w_step_quo = {w_step_quo[XLEN-2:0], w_step_ge};
      w_step_dvs = w_step_dvs >> 1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fast ? c_S_DONE : c_S_CALC;
        end
      end
      c_S_CALC: begin
        if (flush_i) begin
          w_state_nxt = c_S_IDLE;
        end else if (r_count == c_CNT_ONE) begin
          // Last group of quotient bits is retired on this edge
          w_state_nxt = c_S_DONE;
        end
      end
      c_S_DONE: begin
        w_state_nxt = c_S_IDLE;
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    opcode_ready_o = (r_state == c_S_IDLE);
    busy_o         = (r_state == c_S_CALC) || (r_state == c_S_DONE);
    w_res_sel      = r_op[1] ? r_dividend : r_quotient;
    w_res_calc     = r_invert ? -w_res_sel : w_res_sel;
    w_result       = r_fast ? r_fast_res : w_res_calc;
  end

  assign writeback_valid_o = r_wb_valid;
  assign writeback_value_o = r_wb_value;

  // --------------------------------------------------------------------------
  // Datapath, result cache and writeback registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count       <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_quotient    <= '0;
      r_op          <= '0;
      r_invert      <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_fast        <= 1'b0;
      r_fast_res    <= '0;
      r_cache_valid <= 1'b0;
      r_cache_a     <= '0;
      r_cache_b     <= '0;
      r_cache_op    <= '0;
      r_cache_res   <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_value    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (flush_i) begin
        r_cache_valid <= 1'b0;
      end
      case (r_state)
        c_S_IDLE: begin
          if (w_accept) begin
            r_op       <= w_op;
            r_a        <= opcode_ra_operand_i;
            r_b        <= opcode_rb_operand_i;
            r_invert   <= w_invert;
            r_fast     <= w_fast;
            r_fast_res <= w_fast_value;
            r_dividend <= w_a_mag;
            r_divisor  <= {w_b_mag, {(XLEN-1){1'b0}}};
            r_quotient <= '0;
            r_count    <= c_CNT_INIT;
          end
        end
        c_S_CALC: begin
          if (!flush_i) begin
            r_dividend <= w_step_rem;
            r_divisor  <= w_step_dvs;
            r_quotient <= w_step_quo;
            r_count    <= r_count - c_CNT_ONE;
          end
        end
        c_S_DONE: begin
          // A flush in this cycle kills both the strobe and the cache update
          if (!flush_i) begin
            r_wb_valid    <= 1'b1;
            r_wb_value    <= w_result;
            r_cache_valid <= 1'b1;
            r_cache_a     <= r_a;
            r_cache_b     <= r_b;
            r_cache_op    <= r_op;
            r_cache_res   <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biriscv_divider_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_biriscv_divider_param
// Purpose  : Self-checking bench for biriscv_divider_param. Two instances
//            (1 and 4 quotient bits per cycle) are driven with directed and
//            random RV32M divide operations; a behavioural reference model
//            predicts result value, completion cycle and cache behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biriscv_divider_param;

  localparam int NU = 2;
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;
  localparam logic [31:0] REGS   = 32'h00C5_8500;  // rd=x10 rs1=x11 rs2=x12

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid [NU];
  logic [31:0] opw   [NU];
  logic [31:0] ra    [NU];
  logic [31:0] rb    [NU];
  logic        flush [NU];
  logic        ready [NU];
  logic        busy  [NU];
  logic        wbv   [NU];
  logic [31:0] wbval [NU];

  biriscv_divider_param #(
    .XLEN(32), .BITS_PER_CYCLE(1), .LAST_OP_CACHE(1), .EARLY_DIV0(1)
  ) u_div_bpc1 (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_valid_i(valid[0]), .opcode_opcode_i(opw[0]),
    .opcode_ra_operand_i(ra[0]), .opcode_rb_operand_i(rb[0]),
    .flush_i(flush[0]), .opcode_ready_o(ready[0]), .busy_o(busy[0]),
    .writeback_valid_o(wbv[0]), .writeback_value_o(wbval[0])
  );

  biriscv_divider_param #(
    .XLEN(32), .BITS_PER_CYCLE(4), .LAST_OP_CACHE(1), .EARLY_DIV0(1)
  ) u_div_bpc4 (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_valid_i(valid[1]), .opcode_opcode_i(opw[1]),
    .opcode_ra_operand_i(ra[1]), .opcode_rb_operand_i(rb[1]),
    .flush_i(flush[1]), .opcode_ready_o(ready[1]), .busy_o(busy[1]),
    .writeback_valid_o(wbv[1]), .writeback_value_o(wbval[1])
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int steps [NU] = '{32, 8};

  // Model state per unit
  bit          pend   [NU];
  int          due    [NU];
  logic [31:0] expv   [NU];
  logic [31:0] hold   [NU];
  logic [1:0]  pop    [NU];
  logic [31:0] pa     [NU];
  logic [31:0] pb     [NU];
  bit          cvalid [NU];
  logic [1:0]  cop    [NU];
  logic [31:0] ca     [NU];
  logic [31:0] cb     [NU];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int u, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [unit %0d, cycle %0d]: got 0x%08h, expected 0x%08h",
               name, u, cyc, act, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] op_word(input logic [1:0] op);
    case (op)
      OP_DIV:  return 32'h0200_4033 | REGS;
      OP_DIVU: return 32'h0200_5033 | REGS;
      OP_REM:  return 32'h0200_6033 | REGS;
      default: return 32'h0200_7033 | REGS;
    endcase
  endfunction

  // Compare process: every cycle, strobe and held value against the model
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int u = 0; u < NU; u++) begin
          if (pend[u] && (cyc == due[u])) begin
            chk("wb_valid_strobe", u, {31'b0, wbv[u]}, 32'd1);
            chk("wb_value", u, wbval[u], expv[u]);
            hold[u]   = expv[u];
            pend[u]   = 1'b0;
            cvalid[u] = 1'b1;
            cop[u]    = pop[u];
            ca[u]     = pa[u];
            cb[u]     = pb[u];
          end else begin
            chk("wb_valid_quiet", u, {31'b0, wbv[u]}, 32'd0);
            chk("wb_value_hold", u, wbval[u], hold[u]);
          end
        end
      end
    end
  end

  // Issue one op; optionally pin the model against hand-computed literals
  task automatic issue(input int u, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit pin, input logic [31:0] lit,
                       input int lit_lat, input bit wait_done);
    logic [31:0] v;
    bit fast;
    int lat;
    @(negedge clk);
    chk("ready_before_issue", u, {31'b0, ready[u]}, 32'd1);
    valid[u] = 1'b1;
    opw[u]   = op_word(op);
    ra[u]    = a;
    rb[u]    = b;
    @(posedge clk);
    #1;
    valid[u] = 1'b0;
    fast = (b == 0) || (cvalid[u] && cop[u] == op && ca[u] == a && cb[u] == b);
    lat  = fast ? 1 : steps[u] + 1;
    v    = ref_div(op, a, b);
    if (pin) begin
      chk("model_value_pin", u, v, lit);
      chk("model_latency_pin", u, 32'(lat), 32'(lit_lat));
    end
    pend[u] = 1'b1;
    due[u]  = cyc + lat;
    expv[u] = v;
    pop[u]  = op;
    pa[u]   = a;
    pb[u]   = b;
    chk("busy_after_accept", u, {31'b0, busy[u]}, 32'd1);
    chk("ready_after_accept", u, {31'b0, ready[u]}, 32'd0);
    if (wait_done) begin
      for (int k = 0; k < 100 && pend[u]; k++) @(negedge clk);
      if (pend[u]) begin
        n_vec++;
        n_fail++;
        $display("FAIL completion_timeout [unit %0d]: op still pending, required done", u);
        pend[u] = 1'b0;
      end
    end
  endtask

  task automatic idle_checks(input int u);
    chk("ready_idle", u, {31'b0, ready[u]}, 32'd1);
    chk("busy_idle", u, {31'b0, busy[u]}, 32'd0);
  endtask

  task automatic rand_ops(input int u, input int n);
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    op = OP_DIV;
    a  = 32'd1;
    b  = 32'd1;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0: begin op = 2'($urandom_range(0, 3)); a = $urandom; b = 32'd0; end
        1: begin op = 2'($urandom_range(0, 3)); a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin end  // repeat previous op: exercises the cache
        3: begin op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom_range(1, 15); end
        4: begin op = 2'($urandom_range(0, 3)); a = -$urandom_range(1, 999); b = -$urandom_range(1, 20); end
        default: begin op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; end
      endcase
      issue(u, op, a, b, 1'b0, 32'h0, 0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < NU; u++) begin
      valid[u] = 1'b0; opw[u] = 32'h0; ra[u] = 32'h0; rb[u] = 32'h0; flush[u] = 1'b0;
      pend[u] = 1'b0; due[u] = 0; expv[u] = 32'h0; hold[u] = 32'h0; cvalid[u] = 1'b0;
      pop[u] = 2'd0; pa[u] = 32'h0; pb[u] = 32'h0; cop[u] = 2'd0; ca[u] = 32'h0; cb[u] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      idle_checks(u);
      chk("reset_wb_valid", u, {31'b0, wbv[u]}, 32'd0);
      chk("reset_wb_value", u, wbval[u], 32'h0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors, 1 bit per cycle
    issue(0, OP_DIV,  32'd100,       32'd7,         1, 32'd14,         33, 1);
    issue(0, OP_REM,  32'd100,       32'd7,         1, 32'd2,          33, 1);
    issue(0, OP_REM,  -32'sd7,       32'd2,         1, 32'hFFFF_FFFF,  33, 1);
    issue(0, OP_DIV,  -32'sd7,       32'd2,         1, 32'hFFFF_FFFD,  33, 1);
    issue(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2,         1, 32'h7FFF_FFFC,  33, 1);
    issue(0, OP_DIVU, 32'd5,         32'd0,         1, 32'hFFFF_FFFF,  1,  1);
    issue(0, OP_REM,  -32'sd5,       32'd0,         1, 32'hFFFF_FFFB,  1,  1);
    issue(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000,  33, 1);
    issue(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0,          33, 1);
    issue(0, OP_DIV,  32'd100,       32'd7,         1, 32'd14,         33, 1);
    issue(0, OP_DIV,  32'd100,       32'd7,         1, 32'd14,         1,  1);

    // Flush while idle clears the cache: same op iterates fully again
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0]  = 1'b0;
    cvalid[0] = 1'b0;
    issue(0, OP_DIV, 32'd100, 32'd7, 1, 32'd14, 33, 1);

    // Non-divide opcode (MUL) is ignored
    @(negedge clk);
    valid[0] = 1'b1; opw[0] = 32'h0200_0033 | REGS; ra[0] = 32'd6; rb[0] = 32'd7;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    idle_checks(0);

    // Flush in IDLE blocks a same-cycle accept
    @(negedge clk);
    valid[0] = 1'b1; opw[0] = op_word(OP_DIVU); ra[0] = 32'd9; rb[0] = 32'd3; flush[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0; flush[0] = 1'b0; cvalid[0] = 1'b0;
    idle_checks(0);

    // Flush at CALC cycle 10: no writeback, ready next cycle, then a new op
    issue(0, OP_DIV, 32'd100, 32'd7, 0, 32'h0, 0, 0);
    repeat (10) @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0; pend[0] = 1'b0; cvalid[0] = 1'b0;
    idle_checks(0);
    issue(0, OP_REMU, 32'd1000, 32'd33, 1, 32'd10, 33, 1);

    // Flush during DONE of a fast-path op suppresses the strobe
    issue(0, OP_DIVU, 32'd77, 32'd0, 0, 32'h0, 0, 0);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0; pend[0] = 1'b0; cvalid[0] = 1'b0;
    idle_checks(0);
    repeat (3) @(negedge clk);

    // 4 bits per cycle
    issue(1, OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h000C_3BA5, 9, 1);
    issue(1, OP_REMU, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'd1899,      9, 1);
    issue(1, OP_DIV,  -32'sd100,     32'd7,         1, -32'sd14,      9, 1);
    rand_ops(1, 40);
    rand_ops(0, 10);

    // Asynchronous reset in the middle of an operation
    issue(0, OP_DIV, 32'd1000, 32'd3, 0, 32'h0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < NU; u++) begin
      idle_checks(u);
      chk("midop_reset_wb_valid", u, {31'b0, wbv[u]}, 32'd0);
      chk("midop_reset_wb_value", u, wbval[u], 32'h0);
      pend[u] = 1'b0; cvalid[u] = 1'b0; hold[u] = 32'h0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, OP_DIV, 32'd1000, 32'd3, 1, 32'd333, 33, 1);
    issue(1, OP_DIV, 32'd1000, 32'd3, 1, 32'd333, 9,  1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
